// File: rtl/pulse_mon_pkg.sv
// pulse_mon_pkg: shared state encoding and timeout helper for pulse_period_monitor
package pulse_mon_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;
   function automatic int timeout_cycles(input int div);
      return 2 * div;
   endfunction
endpackage

// File: rtl/rise_edge_detect.sv
// rise_edge_detect: one-cycle rise strobe from a clk-synchronous level
// Ports: clk, reset (async, active-high), pulse_in (level), rise (pulse_in & ~pulse_q)
module rise_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic pulse_in,
   output logic rise
);
   logic pulse_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) pulse_q <= 1'b0;
      else       pulse_q <= pulse_in;
   assign rise = pulse_in & ~pulse_q;
endmodule

// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor: measures pulse-to-pulse period and tracks lock to DIV
// Ports: clk, reset (async, active-high), pulse_in, err_clr (sync clear of ERROR),
//        period_out/period_valid (measured period strobe), locked, err,
//        mismatch_cnt (only with PULSE_PERIOD_MISMATCH_CNT_EN defined)
module pulse_period_monitor
   import pulse_mon_pkg::*;
#(
   parameter int DIV      = 3,
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pulse_in,
   input  logic             err_clr,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             locked,
   output logic             err
`ifdef PULSE_PERIOD_MISMATCH_CNT_EN
   ,output logic [7:0]      mismatch_cnt
`endif
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   state_t state, state_d;
   logic [MW-1:0] match_cnt, match_d;
   logic [CNT_W-1:0] cnt, period;
   logic rise, is_div, timeout, clr;
   rise_edge_detect u_red (
      .clk      (clk),
      .reset    (reset),
      .pulse_in (pulse_in),
      .rise     (rise)
   );
   // clear only acts in ERROR and beats a coincident rise
   assign clr     = (state == ST_ERROR) && err_clr;
   assign period  = &cnt ? cnt : cnt + 1'b1;
   assign is_div  = period == CNT_W'(DIV);
   assign timeout = !rise && (cnt == CNT_W'(timeout_cycles(DIV)));
   assign locked  = state == ST_LOCKED;
   assign err     = state == ST_ERROR;
   always_comb begin
      state_d = state;
      match_d = match_cnt;
      case (state)
         ST_IDLE: if (rise) begin
            state_d = ST_ACQ;
            match_d = '0;
         end
         ST_ACQ: if (rise) begin
            match_d = is_div ? match_cnt + 1'b1 : '0;
            if (is_div && (int'(match_cnt) + 1 == LOCK_CNT)) state_d = ST_LOCKED;
         end else if (timeout) begin
            state_d = ST_IDLE;
            match_d = '0;
         end
         ST_LOCKED: if ((rise && !is_div) || timeout) state_d = ST_ERROR;
         default: if (err_clr) begin
            state_d = ST_IDLE;
            match_d = '0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= ST_IDLE;
         match_cnt <= '0;
      end else begin
         state     <= state_d;
         match_cnt <= match_d;
      end
   // period counts from the first rise after IDLE, so that rise reports nothing
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt          <= '0;
         period_out   <= '0;
         period_valid <= 1'b0;
      end else begin
         cnt          <= (rise || clr) ? '0 : period;
         period_valid <= rise && (state != ST_IDLE) && !clr;
         if (rise && (state != ST_IDLE) && !clr) period_out <= period;
      end
`ifdef PULSE_PERIOD_MISMATCH_CNT_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) mismatch_cnt <= '0;
      else if (clr) mismatch_cnt <= '0;
      else if (rise && !is_div && (state == ST_ACQ || state == ST_LOCKED) && !(&mismatch_cnt))
         mismatch_cnt <= mismatch_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb_pulse_period_monitor: directed self-checking bench for pulse_period_monitor
module tb_pulse_period_monitor;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pulse_in = 1'b0;
   logic err_clr = 1'b0;
   logic [7:0] period_out;
   logic period_valid, locked, err;
`ifdef PULSE_PERIOD_MISMATCH_CNT_EN
   logic [7:0] mismatch_cnt;
`endif
   int n_tests = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   pulse_period_monitor #(.DIV(3), .LOCK_CNT(4), .CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .pulse_in     (pulse_in),
      .err_clr      (err_clr),
      .period_out   (period_out),
      .period_valid (period_valid),
      .locked       (locked),
`ifdef PULSE_PERIOD_MISMATCH_CNT_EN
      .mismatch_cnt (mismatch_cnt),
`endif
      .err          (err)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   // drive at negedge, return at next negedge so the sampling edge has passed
   task automatic step(input logic p, input logic c = 1'b0);
      pulse_in = p;
      err_clr  = c;
      @(negedge clk);
      err_clr  = 1'b0;
   endtask
   // zeros then a rise, giving a measured period of p
   task automatic rp(input int p);
      repeat (p - 1) step(1'b0);
      step(1'b1);
   endtask
   initial begin
      #20;
      check("rst_locked", locked, 0);
      check("rst_err", err, 0);
      check("rst_valid", period_valid, 0);
      check("rst_period", period_out, 0);
      #100;
      check("rst_hold", {locked, err, period_valid}, 0);
      @(negedge clk);
      reset = 1'b0;
      // divide-by-3 train
      step(1'b1);
      check("first_valid", period_valid, 0);
      for (int k = 2; k <= 8; k++) begin
         rp(3);
         check("tr_valid", period_valid, 1);
         check("tr_period", period_out, 3);
         check("tr_locked", locked, k >= 5);
         check("tr_err", err, 0);
      end
      step(1'b0);
      check("valid_low", period_valid, 0);
      step(1'b0);
      step(1'b1);
      check("still_locked", locked, 1);
      // off-frequency period while locked
      rp(4);
      check("p4_err", err, 1);
      check("p4_locked", locked, 0);
      check("p4_period", period_out, 4);
      repeat (2) step(1'b0);
      step(1'b1);
      repeat (2) step(1'b0);
      check("err_sticky", err, 1);
      step(1'b0, 1'b1);
      check("clr_err", err, 0);
      check("clr_locked", locked, 0);
      // ACQ timeout back to IDLE
      step(1'b1);
      rp(3);
      rp(3);
      repeat (7) step(1'b0);
      check("acq_to", {locked, err}, 0);
      step(1'b1);
      check("idle_first", period_valid, 0);
      for (int i = 0; i < 4; i++) begin
         rp(3);
         check("relock", locked, i == 3);
      end
      // LOCKED timeout to ERROR
      for (int j = 1; j <= 7; j++) begin
         step(1'b0);
         check("lock_to", err, j == 7);
      end
      step(1'b0, 1'b1);
      check("clr2", err, 0);
      // period sequence 3,3,2,3,3,3,3
      step(1'b1);
      rp(3);
      rp(3);
      rp(2);
      check("p2_period", period_out, 2);
      check("p2_locked", locked, 0);
      for (int i = 0; i < 4; i++) begin
         rp(3);
         check("seq_lock", locked, i == 3);
      end
`ifdef PULSE_PERIOD_MISMATCH_CNT_EN
      check("mismatch", mismatch_cnt, 1);
`endif
      // asynchronous reset while locked
      #2;
      reset = 1'b1;
      pulse_in = 1'b0;
      #1;
      check("async_locked", locked, 0);
      check("async_period", period_out, 0);
      @(negedge clk);
      reset = 1'b0;
      step(1'b1);
      check("post_rst_first", period_valid, 0);
      for (int i = 0; i < 4; i++) begin
         rp(3);
         check("post_rst_lock", locked, i == 3);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
- Receive-side companion to the clock-divider FSMs. It consumes a periodic one-cycle (or wider) pulse stream, such as a divide-by-N output.
- Measures the cycle count between rising edges and reports each measured period.
- A Moore FSM acquires lock after a run of periods equal to DIV, then flags loss of lock as a sticky error.
- Used as the self-check for divider outputs and as a generic "is this pulse train on frequency" monitor.

Parameters:
- DIV, 3, expected period in clk cycles (>=2).
- LOCK_CNT, 4, consecutive matching periods required to enter LOCKED (>=1).
- CNT_W, 8, width of the period counter and period_out; requires 2*DIV < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; forces every register to its reset value immediately.
- pulse_in  input  1  monitored pulse, synchronous to clk.
- err_clr  input  1  synchronous clear of the ERROR state.
- period_out  output  CNT_W  last measured period in cycles.
- period_valid  output  1  one-cycle strobe; period_out was updated this cycle.
- locked  output  1  high while the FSM is in LOCKED.
- err  output  1  high while the FSM is in ERROR.

Behaviour:
- Reset values: period_out=0, period_valid=0, locked=0, err=0, state=IDLE, cnt=0, match_cnt=0, pulse_q=0.
- Edge detection:
  - pulse_q registers pulse_in.
  - rise = pulse_in & ~pulse_q.
  - A level held high produces exactly one rise.
- Counter:
  - On rise, cnt <= 0.
  - Otherwise cnt <= cnt+1, saturating at 2**CNT_W-1.
- Measured period on rise = cnt+1, saturating. A 1-high/2-low train gives period 3.
- period_out and period_valid:
  - Updated on every rise except the first rise after IDLE.
  - Both are registered: they are visible the cycle after the clk edge that sampled the rise.
  - period_valid is low at all other times.
- States are binary-encoded; outputs are pure functions of state (Moore).
  - IDLE: rise -> ACQ, with match_cnt=0.
  - ACQ, on rise with period==DIV: match_cnt++. When match_cnt+1==LOCK_CNT -> LOCKED.
  - ACQ, on rise with period!=DIV: match_cnt=0, stay in ACQ.
  - ACQ, on timeout: -> IDLE.
  - LOCKED, on rise with period!=DIV: -> ERROR.
  - LOCKED, on timeout: -> ERROR.
  - LOCKED, on rise with period==DIV: stay in LOCKED.
  - ERROR: sticky. err_clr -> IDLE and clears cnt/match_cnt. Rises are ignored in ERROR.
- Timeout: cnt==2*DIV with no rise in that cycle. For DIV=3, that is 6 cycles without an edge.
- Simultaneous events:
  - err_clr together with a rise in ERROR: clear wins; the FSM goes to IDLE and the rise is not counted.
  - err_clr outside ERROR has no effect.
  - Timeout and rise in the same cycle: rise wins.
- Reset mid-operation: locked and err drop asynchronously; the next rise after reset release is treated as the first edge.
- Latency: locked/err change on the clock edge after the deciding rise or timeout is sampled.

Optional Feature:
- Macro: PULSE_PERIOD_MISMATCH_CNT_EN.
- Defined:
  - Adds output mismatch_cnt [7:0].
  - It increments on every counted rise whose period!=DIV, in ACQ or LOCKED, saturating at 255.
  - It clears on reset and on err_clr.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pulse_mon_pkg:
  - state encoding localparams ST_IDLE=0, ST_ACQ=1, ST_LOCKED=2, ST_ERROR=3.
  - function for the timeout threshold (2*DIV).
- One sub-module: rise_edge_detect, holding the pulse_q flop plus the rise output, with the same clk/reset.

Test Plan:
1. reset=1 for 20 ns, pulse_in=0 -> locked=0, err=0, period_valid=0, period_out=0. Hold reset 100 ns more -> still all 0.
2. pulse_in 1-high/2-low train (divide-by-3) from the first clk after reset:
   - period_valid strobes every 3 cycles with period_out=3.
   - locked=1 one cycle after the 5th rise (4 matching periods).
   - err stays 0 for 200 ns.
3. Locked, then one period of 4 cycles -> err=1, locked=0 the cycle after that rise, period_out=4.
   - err holds for 50 ns.
   - err_clr pulse -> err=0, state IDLE.
4. In ACQ (after 2 matching rises), pulse_in held 0 -> back to IDLE after 6 cycles, locked=0, err=0.
   - Repeat from LOCKED -> err=1 after 6 cycles.
5. Period sequence 3,3,2,3,3,3,3 -> match_cnt resets at the 2 (period_out=2). locked asserts only after the 4th 3 following the 2.
   - With PULSE_PERIOD_MISMATCH_CNT_EN defined, mismatch_cnt=1.
6. Assert reset asynchronously mid-cycle while locked=1 -> locked drops before the next clk edge.
   - After release, the train re-locks only after 5 rises.
